// File: rtl/compare_tally.sv
// compare_tally
//   Tallies the 3-bit codes produced by an upstream 2-bit magnitude
//   comparator over a window of WIN valid samples. It then holds a report
//   until the consumer acknowledges it.
//
//   Parameters
//     WIN       : valid samples per window (1..255)
//     CW        : width of each count output, at least clog2(WIN+1)
//
//   Ports
//     clk       : rising-edge clock
//     rst_n     : synchronous active-low reset
//     start     : opens a new window (honoured only while idle)
//     y         : compare code, y[2]=A>B, y[1]=A==B, y[0]=A<B
//     y_valid   : y carries a sample this cycle
//     rpt_ack   : consumer has taken the report
//     busy      : window being accumulated or report pending
//     rpt_valid : counts are final and held
//     cnt_gt    : count of code 100 in the current/last window
//     cnt_eq    : count of code 010
//     cnt_lt    : count of code 001
//     cnt_bad   : count of any non-one-hot code
module compare_tally #(
  parameter int WIN = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    y,
  input  logic          y_valid,
  input  logic          rpt_ack,
  output logic          busy,
  output logic          rpt_valid,
  output logic [CW-1:0] cnt_gt,
  output logic [CW-1:0] cnt_eq,
  output logic [CW-1:0] cnt_lt,
  output logic [CW-1:0] cnt_bad
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  // The sample counter value at which the incoming sample is the last one of
  // the window.
  localparam logic [7:0] LAST_IDX = 8'(WIN - 1);

  logic [1:0] state;
  logic [7:0] sample_cnt;

  logic is_gt;
  logic is_eq;
  logic is_lt;
  logic is_bad;

  // Exactly one of the four classes is true for any code. Every pattern that
  // is not one-hot falls into the bad class.
  always_comb begin
    is_gt  = 1'b0;
    is_eq  = 1'b0;
    is_lt  = 1'b0;
    is_bad = 1'b0;
    case (y)
      3'b100:  is_gt  = 1'b1;
      3'b010:  is_eq  = 1'b1;
      3'b001:  is_lt  = 1'b1;
      default: is_bad = 1'b1;
    endcase
  end

  // The FSM, the sample counter and all outputs are kept in one register
  // block, so every output is a flop. Counts are cleared only by start or by
  // reset, so they stay readable after the report has been acknowledged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sample_cnt <= 8'd0;
      busy       <= 1'b0;
      rpt_valid  <= 1'b0;
      cnt_gt     <= '0;
      cnt_eq     <= '0;
      cnt_lt     <= '0;
      cnt_bad    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ACCUM;
            sample_cnt <= 8'd0;
            busy       <= 1'b1;
            cnt_gt     <= '0;
            cnt_eq     <= '0;
            cnt_lt     <= '0;
            cnt_bad    <= '0;
          end
        end

        S_ACCUM: begin
          if (y_valid) begin
            if (is_gt)  cnt_gt  <= cnt_gt  + CW'(1);
            if (is_eq)  cnt_eq  <= cnt_eq  + CW'(1);
            if (is_lt)  cnt_lt  <= cnt_lt  + CW'(1);
            if (is_bad) cnt_bad <= cnt_bad + CW'(1);
            sample_cnt <= sample_cnt + 8'd1;
            // The last sample of the window is counted on the same edge that
            // raises rpt_valid. This gives a report one cycle after that sample.
            if (sample_cnt == LAST_IDX) begin
              state     <= S_REPORT;
              rpt_valid <= 1'b1;
            end
          end
        end

        S_REPORT: begin
          // A start that arrives together with the ack is dropped. The consumer
          // has to raise start again once the block is idle.
          if (rpt_ack) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          rpt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_tally.sv
// Self-checking bench for compare_tally. A WIN=8 instance is run through
// directed scenarios and then through random traffic. Both are checked
// against a window-level reference model. A separate WIN=1 instance checks
// the single-sample window.
module tb_compare_tally;

  localparam int WIN = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, y_valid, rpt_ack;
  logic [2:0]    y;
  logic          busy, rpt_valid;
  logic [CW-1:0] cnt_gt, cnt_eq, cnt_lt, cnt_bad;

  logic       w1_rst_n, w1_start, w1_y_valid, w1_rpt_ack;
  logic [2:0] w1_y;
  logic       w1_busy, w1_rpt_valid;
  logic [0:0] w1_gt, w1_eq, w1_lt, w1_bad;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0=idle, 1=collecting, 2=holding report
  int m_phase = 0;
  int m_taken = 0;
  int m_cnt[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  compare_tally #(.WIN(WIN), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .y_valid(y_valid),
    .rpt_ack(rpt_ack), .busy(busy), .rpt_valid(rpt_valid),
    .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt), .cnt_bad(cnt_bad)
  );

  compare_tally #(.WIN(1), .CW(1)) dut_w1 (
    .clk(clk), .rst_n(w1_rst_n), .start(w1_start), .y(w1_y),
    .y_valid(w1_y_valid), .rpt_ack(w1_rpt_ack), .busy(w1_busy),
    .rpt_valid(w1_rpt_valid), .cnt_gt(w1_gt), .cnt_eq(w1_eq),
    .cnt_lt(w1_lt), .cnt_bad(w1_bad)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Category index: 0=gt, 1=eq, 2=lt, 3=anything that is not exactly one-hot
  function automatic int categoryOf(input logic [2:0] code);
    if ($countones(code) != 1) return 3;
    if (code[2]) return 0;
    if (code[1]) return 1;
    return 2;
  endfunction

  task automatic modelEdge(input logic r, input logic s, input logic [2:0] code,
                           input logic v, input logic a);
    if (!r) begin
      m_phase = 0;
      m_taken = 0;
      m_cnt   = '{0, 0, 0, 0};
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_taken = 0;
        m_cnt   = '{0, 0, 0, 0};
      end
    end else if (m_phase == 1) begin
      if (v) begin
        m_cnt[categoryOf(code)]++;
        m_taken++;
        if (m_taken == WIN) m_phase = 2;
      end
    end else begin
      if (a) m_phase = 0;
    end
  endtask

  // Drives one cycle on the WIN=8 instance, advances the model, then checks
  // every output #1 after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic s,
                               input logic [2:0] code, input logic v,
                               input logic a);
    rst_n = r; start = s; y = code; y_valid = v; rpt_ack = a;
    @(posedge clk);
    modelEdge(r, s, code, v, a);
    #1;
    checkOutput({tag, ".busy"},  32'(busy),      32'(m_phase != 0));
    checkOutput({tag, ".rptv"},  32'(rpt_valid), 32'(m_phase == 2));
    checkOutput({tag, ".gt"},    32'(cnt_gt),    32'(m_cnt[0]));
    checkOutput({tag, ".eq"},    32'(cnt_eq),    32'(m_cnt[1]));
    checkOutput({tag, ".lt"},    32'(cnt_lt),    32'(m_cnt[2]));
    checkOutput({tag, ".bad"},   32'(cnt_bad),   32'(m_cnt[3]));
    if (rpt_valid === 1'b1)
      checkOutput({tag, ".sum"},
                  32'(cnt_gt) + 32'(cnt_eq) + 32'(cnt_lt) + 32'(cnt_bad),
                  32'(WIN));
  endtask

  task automatic stepW1(input logic r, input logic s, input logic [2:0] code,
                        input logic v, input logic a);
    w1_rst_n = r; w1_start = s; w1_y = code; w1_y_valid = v; w1_rpt_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] seq1 [8];
    logic [2:0] seq2 [8];
    seq1 = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
    seq2 = '{3'b000, 3'b111, 3'b011, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};

    w1_rst_n = 1'b0; w1_start = 1'b0; w1_y = 3'b000;
    w1_y_valid = 1'b0; w1_rpt_ack = 1'b0;

    // Reset, including start/valid/ack asserted to confirm reset priority
    applyStimulus("rst0", 1'b0, 1'b1, 3'b100, 1'b1, 1'b1);
    applyStimulus("rst1", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.gt",   32'(cnt_gt), 32'd0);

    // Idle ignores samples and acks
    applyStimulus("idle", 1'b1, 1'b0, 3'b100, 1'b1, 1'b1);

    // Cycling gt/eq/lt window
    applyStimulus("s1.start", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("s1.y%0d", i), 1'b1, 1'b0, seq1[i], 1'b1, 1'b0);
    checkOutput("s1.rpt", 32'(rpt_valid), 32'd1);
    checkOutput("s1.gt",  32'(cnt_gt),  32'd3);
    checkOutput("s1.eq",  32'(cnt_eq),  32'd3);
    checkOutput("s1.lt",  32'(cnt_lt),  32'd2);
    checkOutput("s1.bad", 32'(cnt_bad), 32'd0);

    // Report held against samples and start, then ack
    for (int i = 0; i < 10; i++)
      applyStimulus("s3.hold", 1'b1, (i == 3), 3'b001, 1'b1, 1'b0);
    applyStimulus("s3.ack", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    checkOutput("s3.rpt",  32'(rpt_valid), 32'd0);
    checkOutput("s3.busy", 32'(busy), 32'd0);
    checkOutput("s3.gt",   32'(cnt_gt), 32'd3);

    // Bad codes with y_valid gaps
    applyStimulus("s2.start", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus("s2.gap", 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
      applyStimulus($sformatf("s2.y%0d", i), 1'b1, 1'b0, seq2[i], 1'b1, 1'b0);
    end
    checkOutput("s2.gt",  32'(cnt_gt),  32'd5);
    checkOutput("s2.bad", 32'(cnt_bad), 32'd3);
    checkOutput("s2.rpt", 32'(rpt_valid), 32'd1);

    // Ack and start together: counts kept, start dropped
    applyStimulus("s4.both", 1'b1, 1'b1, 3'b000, 1'b0, 1'b1);
    checkOutput("s4.busy", 32'(busy), 32'd0);
    checkOutput("s4.gt",   32'(cnt_gt), 32'd5);
    applyStimulus("s4.idle", 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    applyStimulus("s4.start", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    checkOutput("s4.clr", 32'(cnt_gt), 32'd0);

    // Reset in the middle of a window, then a clean window
    for (int i = 0; i < 5; i++)
      applyStimulus("s5.acc", 1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
    applyStimulus("s5.rst", 1'b0, 1'b0, 3'b100, 1'b1, 1'b0);
    checkOutput("s5.busy", 32'(busy), 32'd0);
    checkOutput("s5.gt",   32'(cnt_gt), 32'd0);
    applyStimulus("s5.start", 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus("s5.win", 1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    checkOutput("s5.lt", 32'(cnt_lt), 32'd8);
    applyStimulus("s5.ack", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      applyStimulus("rnd", ($urandom_range(63) != 0), ($urandom_range(3) == 0),
                    3'($urandom_range(7)), ($urandom_range(2) != 0),
                    ($urandom_range(3) == 0));

    // Single-sample window
    stepW1(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    checkOutput("w1.busy", 32'(w1_busy), 32'd1);
    checkOutput("w1.rpt0", 32'(w1_rpt_valid), 32'd0);
    stepW1(1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
    checkOutput("w1.rpt", 32'(w1_rpt_valid), 32'd1);
    checkOutput("w1.eq",  32'(w1_eq),  32'd1);
    checkOutput("w1.gt",  32'(w1_gt),  32'd0);
    checkOutput("w1.lt",  32'(w1_lt),  32'd0);
    checkOutput("w1.bad", 32'(w1_bad), 32'd0);
    stepW1(1'b1, 1'b0, 3'b100, 1'b1, 1'b1);
    checkOutput("w1.ack", 32'(w1_busy), 32'd0);
    checkOutput("w1.keep", 32'(w1_eq), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
